edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Watches N single-bit input lines and detects a configurable event on each: a rising edge, or an isolated one-cycle high pulse.
- Each detected event is latched as pending for its channel.
- Pending events are shared onto one valid/ready event stream using round-robin arbitration.
- Sits between raw status/strobe lines and a single event consumer, such as an interrupt or log unit.

Parameters:
- N, default 4: number of input channels; legal range 2..16.
- IDW, default $clog2(N): width of the channel index. Derived; do not override.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
- a, input, N: monitored lines, synchronous to clk.
- mode, input, N: per-channel event type. 0 = rising edge (a was 0, now 1). 1 = one-cycle pulse (history 0,1,0 with the current sample last).
- out_valid, output, 1: an event is presented.
- out_ready, input, 1: consumer accepts the event.
- out_id, output, IDW: channel index of the presented event.
- ovf_clr, input, 1: clears all overflow flags.
- overflow, output, N: sticky per-channel flag; an event was lost.

Behaviour:
- **Reset values.** While rst = 0: two-deep history per channel = 0, pending = 0, out_valid = 0, out_id = 0, overflow = 0, RR pointer = 0. All outputs are registered.
- **History.** Every cycle, each channel shifts its history: h1 <= h0, h0 <= a[i].
- **Detection (combinational, cycle t).**
  - mode = 0: det[i] = !h0 & a[i].
  - mode = 1: det[i] = !h1 & h0 & !a[i].
  - A pulse is therefore reported one cycle after it falls.
  - mode is sampled each cycle. Changing mode mid-stream is legal; the history is not cleared.
- **After reset.** An input already high when reset releases is seen as a rising edge in the first cycle (history reset to 0).
- **Pending.** det[i] at t sets pending[i] at t+1.
  - If pending[i] = 1 and it is not being granted in the same cycle, det[i] leaves pending unchanged and sets overflow[i].
- **Output load.** A load occurs when out_valid = 0, or when out_valid & out_ready.
  - Select the first pending channel at or after the RR pointer, wrapping at N-1 -> 0.
  - Next cycle: out_valid = 1, out_id = selected channel, pending[sel] cleared, pointer = sel + 1 mod N.
  - If nothing is pending: out_valid = 0 and out_id holds its last value.
- **Grant during detection.** det[sel] in the same cycle that sel is granted re-sets pending[sel] with no overflow.
- **Stall.** While out_valid & !out_ready, out_id is held stable and pending keeps accumulating.
- **Throughput.** One event per cycle when out_ready is held at 1.
- **Latency.** The detecting cycle t gives pending at t+1 and out_valid at t+2 minimum.
- **ovf_clr.** ovf_clr = 1 clears overflow next cycle. A new overflow in the same cycle as ovf_clr wins (flag stays set).
- **Reset mid-operation.** Asserting rst drops out_valid immediately (asynchronously) and discards pending events.

Decomposition:
- Package edge_event_pkg: the mode encoding constants MODE_RISE = 1'b0 and MODE_PULSE = 1'b1, and the default N.
- Sub-module rr_arbiter: combinational round-robin selector.
  - Inputs: req[N], ptr[IDW].
  - Outputs: gnt_valid, gnt_id[IDW].
  - Instantiated once.
- History, detection, pending and output registers stay in the top module.

Test Plan:
- Reset release with a = 0000, mode = 0000, out_ready = 1. a[2] goes 0->1 at cycle 5 -> out_valid = 1, out_id = 2 at cycle 7; out_valid = 0 at cycle 8.
- mode[1] = 1, a[1] high for exactly one cycle (cycle 5) -> out_id = 1 at cycle 8. Then a[1] high for two cycles -> no event. Held high with mode[1] = 0 -> exactly one event.
- All four channels rise at the same cycle, out_ready = 1, pointer at 0 -> out_id sequence 0, 1, 2, 3 on consecutive cycles. A repeat starting with the pointer at 2 -> sequence 2, 3, 0, 1.
- out_ready = 0 with channel 3 pending and channel 3 pulsed twice more -> out_id stays 3 and overflow[3] = 1. Pulse ovf_clr -> overflow = 0 next cycle.
- Channel 0 is granted in the same cycle that a new edge on channel 0 is detected -> a second event with id 0 follows and overflow[0] stays 0.
- rst asserted asynchronously while out_valid = 1 with 3 pending -> out_valid = 0 immediately; no events after release until new edges arrive.

Source files
------------

// File: rtl/edge_event_pkg.sv
// ---------------------------------------------------------------------------
// edge_event_pkg : shared constants for the edge/pulse event arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package edge_event_pkg;
  localparam logic MODE_RISE  = 1'b0;
  localparam logic MODE_PULSE = 1'b1;
  localparam int   N_DEFAULT  = 4;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin selector starting at ptr
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import edge_event_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  // Scan from the farthest offset down so the nearest request at/after ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter : per-channel edge/pulse detection, pending latch and
// round-robin serialisation onto one valid/ready event stream.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
  input  logic           ovf_clr,
  output logic [N-1:0]   overflow
);

  logic [N-1:0]   r_h0;
  logic [N-1:0]   r_h1;
  logic [N-1:0]   r_pending;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_det;
  logic           w_load;
  logic           w_gnt_valid;
  logic [IDW-1:0] w_gnt_id;
  logic [N-1:0]   w_gnt_mask;
  logic [N-1:0]   w_ovf_set;

  always_comb begin
    w_det = '0;
    for (int i = 0; i < N; i++) begin
      if (mode[i] == MODE_RISE)
        w_det[i] = !r_h0[i] && a[i];
      else
        w_det[i] = !r_h1[i] && r_h0[i] && !a[i];
    end
  end

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req       (r_pending),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_load     = !out_valid || out_ready;
  assign w_gnt_mask = (w_load && w_gnt_valid) ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
  // A channel being granted this cycle has room for a fresh detection.
  assign w_ovf_set  = w_det & r_pending & ~w_gnt_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h0      <= '0;
      r_h1      <= '0;
      r_pending <= '0;
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      overflow  <= '0;
    end else begin
      r_h1      <= r_h0;
      r_h0      <= a;
      r_pending <= (r_pending & ~w_gnt_mask) | w_det;
      overflow  <= (ovf_clr ? '0 : overflow) | w_ovf_set;
      if (w_load) begin
        out_valid <= w_gnt_valid;
        if (w_gnt_valid) begin
          out_id <= w_gnt_id;
          r_ptr  <= (int'(w_gnt_id) == N - 1) ? '0 : w_gnt_id + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter : directed stimulus with a queue scoreboard of ids.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   a;
  logic [N-1:0]   mode;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_id;
  logic           ovf_clr;
  logic [N-1:0]   overflow;

  int tests  = 0;
  int errors = 0;
  int exp_q[$];

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every accepted event must match the oldest expected id.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got id %0d, expected none", out_id);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(out_id) != e) begin
            errors++;
            $display("FAIL event_id: got %0d, expected %0d", out_id, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; a = '0; mode = '0; out_ready = 1'b1; ovf_clr = 1'b0;

    // Reset state and single rising edge latency.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_id", out_id, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (4) step();
    a[2] = 1'b1; exp_q.push_back(2);
    step();
    check("rise_not_early", out_valid, 0);
    step();
    check("rise_valid", out_valid, 1);
    check("rise_id", out_id, 2);
    step();
    check("rise_valid_drop", out_valid, 0);
    a = '0;
    repeat (2) step();

    // Pulse mode: one-cycle pulse reported after it falls; two-cycle high ignored.
    mode = 4'b0010;
    step();
    a[1] = 1'b1; exp_q.push_back(1);
    step();
    a[1] = 1'b0;
    step();
    check("pulse_not_early", out_valid, 0);
    step();
    check("pulse_valid", out_valid, 1);
    check("pulse_id", out_id, 1);
    repeat (3) step();
    a[1] = 1'b1;
    repeat (2) step();
    a[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("long_pulse_ignored", out_valid, 0);
    end
    mode = '0;
    a[1] = 1'b1; exp_q.push_back(1);
    repeat (6) step();
    a[1] = 1'b0;
    repeat (3) step();

    // Simultaneous rises, pointer 0 then pointer 2.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    a = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    repeat (2) step();
    for (int k = 0; k < 4; k++) begin
      check("burst_valid", out_valid, 1);
      check("burst_id", out_id, k);
      step();
    end
    check("burst_end", out_valid, 0);
    a = '0;
    repeat (2) step();
    a[1] = 1'b1; exp_q.push_back(1);
    repeat (4) step();
    a = '0;
    repeat (2) step();
    a = 4'b1111;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    repeat (8) step();
    a = '0;
    repeat (2) step();

    // Stall with overflow on channel 3, then ovf_clr.
    out_ready = 1'b0;
    a[3] = 1'b1; exp_q.push_back(3);
    repeat (2) step();
    a[3] = 1'b0; step();
    a[3] = 1'b1; exp_q.push_back(3); step();
    a[3] = 1'b0; step();
    a[3] = 1'b1; step();
    a[3] = 1'b0; step();
    check("stall_valid", out_valid, 1);
    check("stall_id", out_id, 3);
    check("stall_overflow", overflow, 4'b1000);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    out_ready = 1'b1;
    repeat (4) step();

    // Grant of channel 0 coincides with a new edge on channel 0.
    out_ready = 1'b0;
    a[1] = 1'b1; exp_q.push_back(1);
    repeat (2) step();
    a[0] = 1'b1; exp_q.push_back(0);
    step();
    a[0] = 1'b0;
    step();
    out_ready = 1'b1;
    a[0] = 1'b1; exp_q.push_back(0);
    repeat (5) step();
    check("regrant_no_overflow", overflow, 0);
    a = '0;
    repeat (2) step();

    // Asynchronous reset while presenting with three pending.
    out_ready = 1'b0;
    a = 4'b1111;
    repeat (2) step();
    check("pre_reset_valid", out_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_id", out_id, 0);
    a = '0;
    repeat (2) step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_reset_quiet", out_valid, 0);
    end
    a[2] = 1'b1; exp_q.push_back(2);
    repeat (4) step();
    a = '0;

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
